// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory read port plus the decode valid/ready handshake.
// master = fetch unit, slave = memory/decode environment.
interface instruction_fetch_unit_if;
  logic [31:0] IM_Address;
  logic [31:0] IM_Instruction;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [31:0] Out_Instruction;
  logic [31:0] Out_PCPlus4;

  modport master (
    output IM_Address,
    input  IM_Instruction,
    output Out_Valid,
    input  Out_Ready,
    output Out_Instruction,
    output Out_PCPlus4
  );

  modport slave (
    input  IM_Address,
    output IM_Instruction,
    input  Out_Valid,
    output Out_Ready,
    input  Out_Instruction,
    input  Out_PCPlus4
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC owner, combinational I-mem read, FIFO buffer towards decode.
// Optional FETCH_PERF_CNT_EN adds Fetch_Count/Stall_Count performance counters.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Fetch_En,
  input  logic        Redirect_Valid,
  input  logic [31:0] Redirect_Target,
  instruction_fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] Fetch_Count,
  output logic [31:0] Stall_Count
`endif
);
  localparam int unsigned   PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned   CW   = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   instr_mem_q [FIFO_DEPTH];
  logic [31:0]   pc4_mem_q   [FIFO_DEPTH];
  logic [31:0]   out_instr_q, out_instr_d;
  logic [31:0]   out_pc4_q, out_pc4_d;
  logic [31:0]   pc_plus4;
  logic          valid, pop, push;

  assign valid               = (count_q != '0);
  assign pc_plus4            = pc_q + 32'd4;
  assign bus.IM_Address      = pc_q & ~32'd3;
  assign bus.Out_Valid       = valid;
  assign bus.Out_Instruction = out_instr_q;
  assign bus.Out_PCPlus4     = out_pc4_q;

  always_comb begin
    pop         = valid && bus.Out_Ready && !Redirect_Valid;
    push        = Fetch_En && !Redirect_Valid && ((count_q < FULL) || pop);
    pc_d        = pc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_instr_d = out_instr_q;
    out_pc4_d   = out_pc4_q;
    if (Redirect_Valid) begin
      pc_d     = Redirect_Target & ~32'd3;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_plus4;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      // Output regs track the next head; the entry being written this cycle bypasses storage.
      if (count_d != '0) begin
        if (push && (wr_ptr_q == rd_ptr_d)) begin
          out_instr_d = bus.IM_Instruction;
          out_pc4_d   = pc_plus4;
        end else begin
          out_instr_d = instr_mem_q[rd_ptr_d];
          out_pc4_d   = pc4_mem_q[rd_ptr_d];
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pc_q        <= RESET_PC & ~32'd3;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_instr_q <= '0;
      out_pc4_q   <= '0;
    end else begin
      pc_q        <= pc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_instr_q <= out_instr_d;
      out_pc4_q   <= out_pc4_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= bus.IM_Instruction;
      pc4_mem_q[wr_ptr_q]   <= pc_plus4;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic stall;
  assign stall = Fetch_En && !Redirect_Valid && (count_q == FULL) && !pop;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Fetch_Count <= '0;
      Stall_Count <= '0;
    end else begin
      if (push)  Fetch_Count <= Fetch_Count + 32'd1;
      if (stall) Stall_Count <= Stall_Count + 32'd1;
    end
  end
`endif
endmodule
